updown_counter_mod: RTL and testbench



---
 rtl/updown_counter_mod_pkg.sv | 30 +++
 rtl/updown_step.sv | 43 ++++
 rtl/updown_counter_mod.sv | 104 ++++++++++
 tb/tb_updown_counter_mod.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_mod_pkg.sv
// Shared definitions for the up/down counter family: mode and direction
// encodings plus the per-edge operation select.
package updown_counter_mod_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2
    } op_e;

    // Resolve the per-edge operation from the strobes, load before enable.
    function automatic op_e select_op(input logic load, input logic en);
        op_e op;
        if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_STEP;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/updown_step.sv
// Combinational single-step of the counter: next value in the chosen direction
// and whether that step pressed against the top or bottom boundary.
import updown_counter_mod_pkg::*;

module updown_step #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] limit,
    input  logic             choice,
    output logic [WIDTH-1:0] q_next,
    output logic             hit_hi,
    output logic             hit_lo
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
    localparam logic             SAT  = (SAT_MODE == CNT_SAT) ? 1'b1 : 1'b0;

    // Step logic; q above limit counts as the top boundary when counting up.
    always_comb begin
        q_next = q;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        if (choice == DIR_UP) begin
            if (q >= limit) begin
                hit_hi = 1'b1;
                q_next = SAT ? limit : ZERO;
            end else begin
                q_next = q + ONE;
            end
        end else begin
            if (q == ZERO) begin
                hit_lo = 1'b1;
                q_next = SAT ? ZERO : limit;
            end else begin
                q_next = q - ONE;
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with runtime limit, wrap/saturate mode, load,
// registered terminal-count pulse and sticky overflow/underflow flags.
import updown_counter_mod_pkg::*;

module updown_counter_mod #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             choice,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_step_q;
    logic             w_hit_hi;
    logic             w_hit_lo;
    op_e              w_op;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tc_next;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_ovf_next;
    logic             w_unf_next;

    updown_step #(
        .WIDTH    (WIDTH),
        .SAT_MODE (SAT_MODE)
    ) u_step (
        .q      (r_q),
        .limit  (limit),
        .choice (choice),
        .q_next (w_step_q),
        .hit_hi (w_hit_hi),
        .hit_lo (w_hit_lo)
    );

    assign w_op = select_op(load, en);

    // Priority mux: a load clamps into range, a step takes the stepper result.
    always_comb begin
        w_q_next  = r_q;
        w_tc_next = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        case (w_op)
            OP_LOAD: begin
                w_q_next = (load_val > limit) ? limit : load_val;
            end
            OP_STEP: begin
                w_q_next  = w_step_q;
                w_tc_next = w_hit_hi | w_hit_lo;
                w_set_ovf = w_hit_hi;
                w_set_unf = w_hit_lo;
            end
            OP_HOLD: begin
                w_q_next = r_q;
            end
            default: begin
                w_q_next = r_q;
            end
        endcase
    end

    // A boundary event in the same cycle as clr_flags keeps its flag set.
    always_comb begin
        w_ovf_next = w_set_ovf | (r_ovf & ~clr_flags);
        w_unf_next = w_set_unf | (r_unf & ~clr_flags);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= {WIDTH{1'b0}};
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_tc  <= w_tc_next;
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;
    assign unf = r_unf;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: a wrap and a saturate instance share stimulus and
// are checked every cycle against an arithmetic model plus directed literals.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       choice = 1'b1;
    logic       load = 1'b1;
    logic [3:0] load_val = 4'd5;
    logic [3:0] limit = 4'd9;
    logic       clr_flags = 1'b0;

    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s, ovf_w, ovf_s, unf_w, unf_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #8 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .SAT_MODE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .choice(choice), .load(load),
        .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
        .q(q_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w)
    );

    updown_counter_mod #(.WIDTH(4), .SAT_MODE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .choice(choice), .load(load),
        .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
        .q(q_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s)
    );

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       ovf;
        logic       unf;
    } mstate_t;

    mstate_t m_wrap, m_sat;
    bit      m_valid = 1'b0;

    function automatic mstate_t mstep(input mstate_t cur, input bit sat);
        mstate_t n;
        int qv, lim;
        bit up_hit, dn_hit;
        n = cur;
        qv = int'(cur.q);
        lim = int'(limit);
        up_hit = 1'b0;
        dn_hit = 1'b0;
        n.tc = 1'b0;
        if (reset) begin
            return '0;
        end
        if (load) begin
            n.q = (int'(load_val) < lim) ? load_val : limit;
        end else if (en && choice) begin
            if (qv >= lim) begin
                up_hit = 1'b1;
                n.q = sat ? limit : 4'd0;
            end else begin
                n.q = 4'(qv + 1);
            end
        end else if (en) begin
            if (qv == 0) begin
                dn_hit = 1'b1;
                n.q = sat ? 4'd0 : limit;
            end else begin
                n.q = 4'(qv - 1);
            end
        end
        n.tc  = up_hit | dn_hit;
        n.ovf = up_hit | (cur.ovf & ~clr_flags);
        n.unf = dn_hit | (cur.unf & ~clr_flags);
        return n;
    endfunction

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk) begin
        m_wrap <= mstep(m_wrap, 1'b0);
        m_sat  <= mstep(m_sat, 1'b1);
        if (reset) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model wrap q",   q_w,   m_wrap.q);
            chk("model wrap tc",  tc_w,  m_wrap.tc);
            chk("model wrap ovf", ovf_w, m_wrap.ovf);
            chk("model wrap unf", unf_w, m_wrap.unf);
            chk("model sat q",    q_s,   m_sat.q);
            chk("model sat tc",   tc_s,  m_sat.tc);
            chk("model sat ovf",  ovf_s, m_sat.ovf);
            chk("model sat unf",  unf_s, m_sat.unf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held 2 edges with en, up and load all active.
        tick();
        tick();
        chk("reset q wrap", q_w, 0);
        chk("reset tc wrap", tc_w, 0);
        chk("reset ovf wrap", ovf_w, 0);
        chk("reset unf wrap", unf_w, 0);
        chk("reset q sat", q_s, 0);
        chk("reset tc sat", tc_s, 0);
        chk("reset ovf sat", ovf_s, 0);
        chk("reset unf sat", unf_s, 0);

        // Wrap up: 0..9 then 0 with a single tc cycle.
        reset = 1'b0; load = 1'b0; en = 1'b1; choice = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("wrap up q", q_w, k % 10);
            chk("wrap up tc", tc_w, (k == 10) ? 1 : 0);
        end
        chk("wrap up ovf", ovf_w, 1);
        chk("sat up q held", q_s, 9);

        // Wrap down from 0.
        choice = 1'b0;
        tick();
        chk("wrap down q", q_w, 9);
        chk("wrap down tc", tc_w, 1);
        chk("wrap down unf", unf_w, 1);
        for (int k = 0; k < 9; k++) tick();
        chk("wrap down9 q", q_w, 0);
        chk("wrap down9 tc", tc_w, 0);

        // clr_flags alone.
        en = 1'b0; clr_flags = 1'b1;
        tick();
        chk("clr ovf", ovf_w, 0);
        chk("clr unf", unf_w, 0);
        clr_flags = 1'b0;

        // Saturate: load clamps, then presses against the top.
        load = 1'b1; load_val = 4'd14;
        tick();
        chk("sat load clamp", q_s, 9);
        load = 1'b0; en = 1'b1; choice = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sat hold q", q_s, 9);
            chk("sat hold tc", tc_s, 1);
        end
        chk("sat ovf", ovf_s, 1);
        choice = 1'b0;
        tick();
        chk("sat down q", q_s, 8);
        chk("sat down tc", tc_s, 0);

        // Load beats enable.
        load = 1'b1; load_val = 4'd3; en = 1'b1; choice = 1'b1;
        tick();
        chk("load+en q", q_w, 3);
        chk("load+en tc", tc_w, 0);

        // Limit lowered below q: down counts normally, up is a boundary.
        load_val = 4'd7;
        tick();
        load = 1'b0; limit = 4'd3; choice = 1'b0;
        tick();
        chk("over-limit down q", q_w, 6);
        choice = 1'b1;
        tick();
        chk("over-limit up q", q_w, 0);
        chk("over-limit up tc", tc_w, 1);
        chk("over-limit up sat q", q_s, 3);

        // limit = 0: every enabled step is a boundary.
        limit = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lim0 q", q_w, 0);
            chk("lim0 tc", tc_w, 1);
            chk("lim0 sat q", q_s, 0);
        end
        choice = 1'b0;
        tick();
        chk("lim0 down tc", tc_w, 1);
        chk("lim0 down unf", unf_w, 1);

        // clr_flags coincident with an up boundary: set wins.
        limit = 4'd9; en = 1'b0; clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; choice = 1'b1; clr_flags = 1'b1;
        tick();
        chk("clr+hit ovf", ovf_w, 1);
        chk("clr+hit q", q_w, 0);
        chk("clr+hit unf", unf_w, 0);
        en = 1'b0;
        tick();
        chk("clr after ovf", ovf_w, 0);
        chk("clr after unf", unf_w, 0);
        clr_flags = 1'b0;

        // Direction toggles every 5 edges with random enable.
        for (int k = 0; k < 60; k++) begin
            if (k % 5 == 0) choice = ~choice;
            en = 1'($urandom_range(0, 1));
            tick();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
